// File: rtl/chip8_mem_seq_pkg.sv
// Shared definitions for the CHIP-8 FX33/FX55/FX65 transfer sequencer:
// op encodings, FSM state encodings, BCD digit count and a digit-select helper.
package chip8_mem_seq_pkg;

  typedef enum logic [1:0] {
    OP_BCD   = 2'd0,
    OP_STORE = 2'd1,
    OP_LOAD  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BCD_CONV = 3'd1;
  localparam logic [2:0] ST_BCD_WR   = 3'd2;
  localparam logic [2:0] ST_STORE    = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;

  localparam int BCD_DIGITS = 3;

  // Digit 0 is the hundreds digit, written first at address I.
  function automatic logic [3:0] bcd_digit(input logic [11:0] acc, input logic [1:0] idx);
    case (idx)
      2'd0:    bcd_digit = acc[11:8];
      2'd1:    bcd_digit = acc[7:4];
      default: bcd_digit = acc[3:0];
    endcase
  endfunction

endpackage

// File: rtl/chip8_mem_seq_if.sv
// RAM and register-file bus driven by the transfer sequencer; the sequencer is
// the master, the memory/register-file side is the slave.
interface chip8_mem_seq_if #(
  parameter int ADDR_W = 12,
  parameter int REG_W  = 4
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic [REG_W-1:0]  reg_ridx;
  logic [7:0]        reg_rdata;
  logic [REG_W-1:0]  reg_widx;
  logic [7:0]        reg_wdata;
  logic              reg_we;

  modport master (
    output mem_addr, mem_wdata, mem_we, reg_ridx, reg_widx, reg_wdata, reg_we,
    input  mem_rdata, reg_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, reg_ridx, reg_widx, reg_wdata, reg_we,
    output mem_rdata, reg_rdata
  );
endinterface

// File: rtl/chip8_mem_seq_bin2bcd_seq.sv
// bin2bcd_seq: 8-bit sequential double-dabble converter, one iteration per cycle.
// done is high during the final iteration; bcd is final on the following cycle.
module bin2bcd_seq
  import chip8_mem_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  din,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]  sh_q;
  logic [11:0] acc_q;
  logic [2:0]  cnt_q;
  logic        run_q;
  logic [11:0] adj;

  always_comb begin
    adj = acc_q;
    for (int unsigned n = 0; n < BCD_DIGITS; n++) begin
      if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= din;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      {acc_q, sh_q} <= {adj, sh_q} << 1;
      cnt_q         <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_q <= 1'b0;
    end
  end

  assign bcd  = acc_q;
  assign done = run_q && (cnt_q == 3'd7);

endmodule

// File: rtl/chip8_mem_seq.sv
// Multi-cycle FX33/FX55/FX65 sequencer between the execute stage, register file and RAM.
// Define CHIP8_I_INCREMENT_EN for COSMAC behaviour (STORE/LOAD advance I by x+1).
module chip8_mem_seq
  import chip8_mem_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [3:0]        x,
  input  logic [ADDR_W-1:0] i_in,
  input  logic [7:0]        vx_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] i_out,
  output logic              i_update,
  chip8_mem_seq_if.master   bus
);

  localparam int REG_W = $clog2(NREGS);

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        last_q;
  logic [3:0]        k_q;
  logic              rd_act_q;
  logic [1:0]        didx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [REG_W-1:0]  reg_ridx_q;
  logic [REG_W-1:0]  reg_widx_q;
  logic              reg_we_q;
  logic              busy_q, done_q, err_q;
  logic [3:0]        x_cl;
  logic              conv_start, conv_done;
  logic [11:0]       conv_bcd;
`ifdef CHIP8_I_INCREMENT_EN
  logic [ADDR_W-1:0] i_out_q;
  logic              i_upd_q;
`endif

  assign x_cl       = (int'(x) >= NREGS) ? 4'(NREGS - 1) : x;
  assign conv_start = (state == ST_IDLE) && start && (op == OP_BCD);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .din   (vx_in),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      last_q     <= '0;
      k_q        <= '0;
      rd_act_q   <= 1'b0;
      didx_q     <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      reg_ridx_q <= '0;
      reg_widx_q <= '0;
      reg_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CHIP8_I_INCREMENT_EN
      i_out_q    <= '0;
      i_upd_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q   <= i_in;
            last_q   <= x_cl;
            k_q      <= '0;
            rd_act_q <= 1'b1;
            busy_q   <= 1'b1;
            case (op)
              OP_BCD:   state <= ST_BCD_CONV;
              OP_STORE: begin
                state      <= ST_STORE;
                reg_ridx_q <= '0;
              end
              OP_LOAD: begin
                state      <= ST_LOAD;
                mem_addr_q <= i_in;
              end
              default: begin
                state  <= ST_FINISH;
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end
        ST_BCD_CONV: begin
          if (conv_done) begin
            state      <= ST_BCD_WR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= base_q;
            didx_q     <= '0;
          end
        end
        ST_BCD_WR: begin
          if (didx_q == 2'(BCD_DIGITS - 1)) begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            didx_q     <= didx_q + 2'd1;
            mem_addr_q <= base_q + ADDR_W'(didx_q) + ADDR_W'(1);
          end
        end
        // Read k is issued while write k-1 is in flight; rd_act_q drops after the last read.
        ST_STORE: begin
          if (rd_act_q) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= base_q + ADDR_W'(k_q);
            if (k_q == last_q) begin
              rd_act_q <= 1'b0;
            end else begin
              k_q        <= k_q + 4'd1;
              reg_ridx_q <= REG_W'(k_q + 4'd1);
            end
          end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_FINISH;
`ifdef CHIP8_I_INCREMENT_EN
            i_out_q  <= base_q + ADDR_W'(last_q) + ADDR_W'(1);
            i_upd_q  <= 1'b1;
`endif
          end
        end
        ST_LOAD: begin
          if (rd_act_q) begin
            reg_we_q   <= 1'b1;
            reg_widx_q <= REG_W'(k_q);
            if (k_q == last_q) begin
              rd_act_q <= 1'b0;
            end else begin
              k_q        <= k_q + 4'd1;
              mem_addr_q <= base_q + ADDR_W'(k_q) + ADDR_W'(1);
            end
          end else begin
            reg_we_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_FINISH;
`ifdef CHIP8_I_INCREMENT_EN
            i_out_q  <= base_q + ADDR_W'(last_q) + ADDR_W'(1);
            i_upd_q  <= 1'b1;
`endif
          end
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          err_q  <= 1'b0;
`ifdef CHIP8_I_INCREMENT_EN
          i_upd_q <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write data is forwarded from the read port in its valid cycle and forced to 0 otherwise.
  always_comb begin
    bus.mem_wdata = '0;
    if (mem_we_q && state == ST_STORE)       bus.mem_wdata = bus.reg_rdata;
    else if (mem_we_q && state == ST_BCD_WR) bus.mem_wdata = {4'd0, bcd_digit(conv_bcd, didx_q)};
  end

  assign bus.reg_wdata = reg_we_q ? bus.mem_rdata : '0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.reg_ridx  = reg_ridx_q;
  assign bus.reg_widx  = reg_widx_q;
  assign bus.reg_we    = reg_we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

`ifdef CHIP8_I_INCREMENT_EN
  assign i_out    = i_out_q;
  assign i_update = i_upd_q;
`else
  assign i_out    = base_q;
  assign i_update = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_mem_seq.sv
// Bench for chip8_mem_seq: RAM/register-file environment plus a transaction-level
// reference that predicts every write event, its cycle, and the done/err/I outcome.
module tb_chip8_mem_seq;

  localparam int ADDR_W = 12;
  localparam int NREGS  = 16;
  localparam int REG_W  = $clog2(NREGS);
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        op = '0;
  logic [3:0]        x = '0;
  logic [ADDR_W-1:0] i_in = '0;
  logic [7:0]        vx_in = '0;
  logic              busy, done, err, i_update;
  logic [ADDR_W-1:0] i_out;

  chip8_mem_seq_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  chip8_mem_seq #(.ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .x        (x),
    .i_in     (i_in),
    .vx_in    (vx_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .i_out    (i_out),
    .i_update (i_update),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Environment: synchronous RAM and register file, with a bench preload port.
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic [7:0]        rf  [0:NREGS-1];
  logic              env_clr = 1'b1, pre_we = 1'b0, pre_rf = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_data = '0;

  always @(posedge clk) begin
    if (env_clr) begin
      for (int n = 0; n < (1 << ADDR_W); n++) ram[n] <= '0;
      for (int n = 0; n < NREGS; n++) rf[n] <= '0;
    end else begin
      if (pre_we && !pre_rf) ram[pre_addr] <= pre_data;
      if (pre_we && pre_rf)  rf[pre_addr[REG_W-1:0]] <= pre_data;
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.reg_we) rf[bus.reg_widx] <= bus.reg_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
    bus.reg_rdata <= rf[bus.reg_ridx];
  end

  // Reference contents of RAM and V registers.
  logic [7:0] exp_ram [0:(1<<ADDR_W)-1];
  logic [7:0] exp_rf  [0:NREGS-1];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pk(input int c, input int a, input int d);
    return (c << 24) | (a << 8) | d;
  endfunction

  task automatic poke(input bit to_rf, input int addr, input int data);
    @(negedge clk);
    pre_we = 1'b1; pre_rf = to_rf; pre_addr = ADDR_W'(addr); pre_data = 8'(data);
    @(negedge clk);
    pre_we = 1'b0;
    if (to_rf) exp_rf[addr % NREGS] = 8'(data);
    else       exp_ram[addr & AMASK] = 8'(data);
  endtask

  // Called at a falling edge; start is sampled on the next rising edge (cycle 0).
  // inj > 0 pulses a stray STORE request in that cycle, which must be ignored.
  task automatic run_op(input int o, input int xi, input int ia, input int v, input int inj);
    int exp_m[$], exp_r[$], obs_m[$], obs_r[$];
    int xc, dcyc, exp_d, ups, clash, busy_lo, n;
    logic err_d;
    logic [ADDR_W-1:0] iout_d;
    string t;
    t = $sformatf("op%0d x%0d i%03h", o, xi, ia);
    xc = (xi >= NREGS) ? NREGS - 1 : xi;
    err_d = 1'b0; iout_d = '0; dcyc = 0; ups = 0; clash = 0; busy_lo = 0;

    case (o)
      0: begin
        exp_m.push_back(pk(9,  (ia)     & AMASK, v / 100));
        exp_m.push_back(pk(10, (ia + 1) & AMASK, (v / 10) % 10));
        exp_m.push_back(pk(11, (ia + 2) & AMASK, v % 10));
        exp_ram[(ia)     & AMASK] = 8'(v / 100);
        exp_ram[(ia + 1) & AMASK] = 8'((v / 10) % 10);
        exp_ram[(ia + 2) & AMASK] = 8'(v % 10);
        exp_d = 12;
      end
      1: begin
        for (int k = 0; k <= xc; k++) exp_m.push_back(pk(2 + k, (ia + k) & AMASK, int'(exp_rf[k])));
        for (int k = 0; k <= xc; k++) exp_ram[(ia + k) & AMASK] = exp_rf[k];
        exp_d = xc + 3;
      end
      2: begin
        for (int k = 0; k <= xc; k++) exp_r.push_back(pk(2 + k, k, int'(exp_ram[(ia + k) & AMASK])));
        for (int k = 0; k <= xc; k++) exp_rf[k] = exp_ram[(ia + k) & AMASK];
        exp_d = xc + 3;
      end
      default: exp_d = 1;
    endcase

    start = 1'b1; op = 2'(o); x = 4'(xi); i_in = ADDR_W'(ia); vx_in = 8'(v);
    @(posedge clk);
    for (int c = 1; c <= 40 && dcyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (inj != 0 && c == inj) begin
        start = 1'b1; op = 2'd1; x = 4'd5; i_in = ADDR_W'($urandom_range(0, AMASK));
      end
      if (inj != 0 && c == inj + 1) start = 1'b0;
      if (bus.mem_we) obs_m.push_back(pk(c, int'(bus.mem_addr), int'(bus.mem_wdata)));
      if (bus.reg_we) obs_r.push_back(pk(c, int'(bus.reg_widx), int'(bus.reg_wdata)));
      if (bus.mem_we && bus.reg_we) clash++;
      if (i_update) ups++;
      if (!busy) busy_lo++;
      if (done) begin
        dcyc = c; err_d = err; iout_d = i_out;
      end
    end
    start = 1'b0;

    check_eq({t, " done_cycle"}, dcyc, exp_d);
    check_eq({t, " err"}, err_d, (o == 3));
    check_eq({t, " busy_gap"}, busy_lo, 0);
    check_eq({t, " we_clash"}, clash, 0);
    check_eq({t, " mem_writes"}, obs_m.size(), exp_m.size());
    n = (obs_m.size() < exp_m.size()) ? obs_m.size() : exp_m.size();
    for (int k = 0; k < n; k++) check_eq($sformatf("%s mem_ev%0d", t, k), obs_m[k], exp_m[k]);
    check_eq({t, " reg_writes"}, obs_r.size(), exp_r.size());
    n = (obs_r.size() < exp_r.size()) ? obs_r.size() : exp_r.size();
    for (int k = 0; k < n; k++) check_eq($sformatf("%s reg_ev%0d", t, k), obs_r[k], exp_r[k]);
`ifdef CHIP8_I_INCREMENT_EN
    check_eq({t, " i_update_cnt"}, ups, (o == 1 || o == 2) ? 1 : 0);
    if (o == 1 || o == 2) check_eq({t, " i_out"}, iout_d, (ia + xc + 1) & AMASK);
`else
    check_eq({t, " i_update_cnt"}, ups, 0);
    check_eq({t, " i_out"}, iout_d, ia & AMASK);
`endif

    @(negedge clk);
    check_eq({t, " busy_after"}, {busy, done}, 2'b00);
  endtask

  int quiet;

  initial begin
    for (int n = 0; n < (1 << ADDR_W); n++) exp_ram[n] = '0;
    for (int n = 0; n < NREGS; n++) exp_rf[n] = '0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_flags", {busy, done, err, i_update, bus.mem_we, bus.reg_we}, '0);
    check_eq("reset_mem", {bus.mem_addr, bus.mem_wdata}, '0);
    check_eq("reset_reg", {bus.reg_ridx, bus.reg_widx, bus.reg_wdata, i_out}, '0);
    env_clr = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_op(0, 0, 'h300, 157, 0);
    run_op(0, 0, 'h300, 0,   0);
    run_op(0, 0, 'h300, 255, 0);

    poke(1, 0, 'h11); poke(1, 1, 'h22); poke(1, 2, 'h33); poke(1, 3, 'h44);
    run_op(1, 3, 'h400, 0, 0);

    poke(0, 'hFFE, 'hAA); poke(0, 'hFFF, 'hBB); poke(0, 'h000, 'hCC);
    run_op(2, 2, 'hFFE, 0, 2);
    run_op(3, 0, 'h123, 0, 0);

    // Reset in cycle 3 of STORE x=7: only the k=0 write (cycle 2) has landed.
    start = 1'b1; op = 2'd1; x = 4'd7; i_in = 'h500;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check_eq("midrst_flags", {busy, done, err, i_update, bus.mem_we, bus.reg_we}, '0);
    check_eq("midrst_mem", {bus.mem_addr, bus.mem_wdata}, '0);
    check_eq("midrst_reg", {bus.reg_ridx, bus.reg_widx, bus.reg_wdata, i_out}, '0);
    exp_ram['h500] = exp_rf[0];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    quiet = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_we || bus.reg_we || busy) quiet++;
    end
    check_eq("midrst_quiet", quiet, 0);
    run_op(1, 0, 'h123, 0, 0);

    // LOAD back the aborted STORE region to confirm only the first byte landed.
    run_op(2, 1, 'h500, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int o, xi, ia, v, inj;
      o   = $urandom_range(0, 3);
      xi  = $urandom_range(0, 15);
      ia  = $urandom_range(0, AMASK);
      v   = $urandom_range(0, 255);
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if (o == 3 || (o == 1 && xi == 0)) inj = (inj != 0) ? 1 : 0;
      if ($urandom_range(0, 1) == 1) poke(1, $urandom_range(0, NREGS - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) poke(0, (ia + $urandom_range(0, 15)) & AMASK, $urandom_range(0, 255));
      run_op(o, xi, ia, v, inj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
